// File: rtl/puf_response_collector.sv
// Arbiter-PUF response collector: drives challenges and launch pulses to a delay
// line, majority-votes N_VOTES races per bit and assembles an 8-bit response word.
module puf_response_collector #(
  parameter int N_VOTES       = 5,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       istart,
  input  logic [7:0] iseed,
  output logic [7:0] ochallenge,
  output logic       opulse,
  input  logic       iresponse,
  output logic [7:0] oresp_word,
  output logic       ovalid,
  input  logic       iready,
  output logic       obusy,
  output logic       ounstable
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] LAUNCH = 3'd2;
  localparam logic [2:0] VOTE   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [4:0] SETUP_LAST  = 5'(SETTLE_CYCLES - 1);
  localparam logic [4:0] LAUNCH_LAST = 5'(SETTLE_CYCLES + 1);
  localparam logic [3:0] VOTES       = 4'(N_VOTES);
  localparam logic [3:0] HALF_VOTES  = 4'(N_VOTES / 2);

  logic [2:0] state;
  logic [4:0] tmr;
  logic [3:0] vote_cnt;
  logic [3:0] ones;
  logic [2:0] bit_cnt;
  logic       sync_p0;
  logic       sync_p1;

  function automatic logic majority(input logic [3:0] n_ones);
    return n_ones > HALF_VOTES;
  endfunction

  function automatic logic split_vote(input logic [3:0] n_ones);
    return (n_ones != 4'd0) && (n_ones != VOTES);
  endfunction

  function automatic logic [7:0] next_challenge(input logic [7:0] c);
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

  // arbiter latch is asynchronous to clk: two-flop synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= iresponse;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tmr        <= 5'd0;
      vote_cnt   <= 4'd0;
      ones       <= 4'd0;
      bit_cnt    <= 3'd0;
      ochallenge <= 8'h00;
      oresp_word <= 8'h00;
      ounstable  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (istart) begin
            state      <= SETUP;
            tmr        <= 5'd0;
            vote_cnt   <= 4'd0;
            ones       <= 4'd0;
            bit_cnt    <= 3'd0;
            oresp_word <= 8'h00;
            ounstable  <= 1'b0;
            ochallenge <= (iseed == 8'h00) ? 8'h01 : iseed;
          end
        end
        SETUP: begin
          if (tmr == SETUP_LAST) begin
            tmr   <= 5'd0;
            state <= LAUNCH;
          end else begin
            tmr <= tmr + 5'd1;
          end
        end
        LAUNCH: begin
          if (tmr == LAUNCH_LAST) begin
            tmr      <= 5'd0;
            ones     <= ones + {3'b000, sync_p1};
            vote_cnt <= vote_cnt + 4'd1;
            state    <= ((vote_cnt + 4'd1) < VOTES) ? SETUP : VOTE;
          end else begin
            tmr <= tmr + 5'd1;
          end
        end
        VOTE: begin
          oresp_word <= {oresp_word[6:0], majority(ones)};
          if (split_vote(ones)) ounstable <= 1'b1;
          ochallenge <= next_challenge(ochallenge);
          vote_cnt   <= 4'd0;
          ones       <= 4'd0;
          bit_cnt    <= bit_cnt + 3'd1;
          state      <= (bit_cnt == 3'd7) ? DONE : SETUP;
        end
        DONE: begin
          if (iready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // outputs decode straight from the state register so reset clears them at once
  assign opulse = (state == LAUNCH);
  assign ovalid = (state == DONE);
  assign obusy  = (state != IDLE);

endmodule

// File: tb/tb_puf_response_collector.sv
// Directed bench for puf_response_collector with a behavioural arbiter model and a
// scoreboard of expected response words.
module tb_puf_response_collector;

  localparam int N_VOTES       = 5;
  localparam int SETTLE_CYCLES = 2;
  localparam int LAT           = 8 * (N_VOTES * (2 * SETTLE_CYCLES + 2) + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       istart;
  logic [7:0] iseed;
  logic [7:0] ochallenge;
  logic       opulse;
  logic       iresponse;
  logic [7:0] oresp_word;
  logic       ovalid;
  logic       iready;
  logic       obusy;
  logic       ounstable;

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  int pcount = 0;
  int pstart = 0;
  logic [7:0] chal_log [0:4095];
  logic [8:0] sb [$];

  puf_response_collector #(.N_VOTES(N_VOTES), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .clk(clk), .rst(rst), .istart(istart), .iseed(iseed), .ochallenge(ochallenge),
    .opulse(opulse), .iresponse(iresponse), .oresp_word(oresp_word), .ovalid(ovalid),
    .iready(iready), .obusy(obusy), .ounstable(ounstable)
  );

  always #5 clk = ~clk;

  // each launch pulse: log the challenge seen by the delay line and advance the vote index
  always @(posedge opulse) begin
    chal_log[pcount[11:0]] = ochallenge;
    pcount = pcount + 1;
  end

  function automatic logic arbiter(input int m, input int vote, input logic [7:0] c);
    case (m)
      1:       return c[0];
      2:       return vote <= 3;
      3:       return vote <= 2;
      default: return 1'b1;
    endcase
  endfunction

  assign iresponse = arbiter(mode, ((pcount - pstart - 1) % N_VOTES) + 1, ochallenge);

  function automatic logic [7:0] lfsr(input logic [7:0] c);
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

  function automatic logic [7:0] chal_at(input logic [7:0] seed, input int b);
    logic [7:0] c;
    c = (seed == 8'h00) ? 8'h01 : seed;
    for (int i = 0; i < b; i++) c = lfsr(c);
    return c;
  endfunction

  function automatic logic [8:0] model(input int m, input logic [7:0] seed);
    logic [7:0] w;
    logic [7:0] c;
    logic       b;
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      c = chal_at(seed, i);
      b = (m == 1) ? c[0] : (m == 3) ? 1'b0 : 1'b1;
      w = {w[6:0], b};
    end
    return {(m >= 2) ? 1'b1 : 1'b0, w};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_word(input logic [7:0] seed);
    pstart = pcount;
    @(negedge clk);
    iseed  = seed;
    istart = 1'b1;
    @(negedge clk);
    istart = 1'b0;
  endtask

  task automatic run(input int m, input logic [7:0] seed, input bit hold, input bit early);
    int n;
    logic [8:0] exp;
    mode   = m;
    iready = early;
    sb.push_back(model(m, seed));
    start_word(seed);
    n = 0;
    while (!ovalid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, LAT);
    exp = sb.pop_front();
    check("word", {24'h0, oresp_word}, {24'h0, exp[7:0]});
    check("unstable", {31'h0, ounstable}, {31'h0, exp[8]});
    check("pulse_count", pcount - pstart, 8 * N_VOTES);
    for (int b = 0; b < 8; b++)
      for (int v = 0; v < N_VOTES; v++)
        check("challenge", {24'h0, chal_log[12'(pstart + b * N_VOTES + v)]},
              {24'h0, chal_at(seed, b)});
    if (early) begin
      @(negedge clk);
      check("ovalid_drop_early", {31'h0, ovalid}, 32'h0);
      check("obusy_drop_early", {31'h0, obusy}, 32'h0);
      iready = 1'b0;
    end else begin
      if (hold) begin
        for (int i = 0; i < 10; i++) begin
          istart = 1'b1;
          iseed  = 8'h33;
          @(negedge clk);
          istart = 1'b0;
          check("hold_valid", {31'h0, ovalid}, 32'h1);
          check("hold_word", {24'h0, oresp_word}, {24'h0, exp[7:0]});
        end
      end
      iready = 1'b1;
      istart = 1'b1;
      @(negedge clk);
      iready = 1'b0;
      istart = 1'b0;
      check("ovalid_drop", {31'h0, ovalid}, 32'h0);
      check("obusy_drop", {31'h0, obusy}, 32'h0);
      @(negedge clk);
      check("idle_after_hs", {31'h0, obusy}, 32'h0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_opulse"}, {31'h0, opulse}, 32'h0);
    check({tag, "_obusy"}, {31'h0, obusy}, 32'h0);
    check({tag, "_ovalid"}, {31'h0, ovalid}, 32'h0);
    check({tag, "_unstable"}, {31'h0, ounstable}, 32'h0);
    check({tag, "_word"}, {24'h0, oresp_word}, 32'h0);
    check({tag, "_chal"}, {24'h0, ochallenge}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst    = 1'b1;
    istart = 1'b0;
    iseed  = 8'h00;
    iready = 1'b0;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_por", {31'h0, obusy}, 32'h0);

    run(0, 8'h01, 1'b0, 1'b0);
    run(1, 8'h01, 1'b0, 1'b0);
    run(2, 8'h5A, 1'b0, 1'b1);
    run(3, 8'h00, 1'b1, 1'b0);

    // abort a word at edge 100 with an asynchronous reset
    mode = 0;
    start_word(8'h01);
    repeat (100) @(negedge clk);
    check("busy_before_rst", {31'h0, obusy}, 32'h1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst100");
    @(negedge clk);
    rst = 1'b0;

    // abort in the middle of a launch pulse
    start_word(8'h01);
    n = 0;
    while (!opulse && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pulse_seen", {31'h0, opulse}, 32'h1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_launch");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", {31'h0, obusy}, 32'h0);

    run(0, 8'h01, 1'b0, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
